// File: rtl/hazard_unit.sv
// Load-use / branch / memory-wait hazard controller for a 5-stage pipeline.
// Optional saturating perf counters are enabled with macro HAZARD_UNIT_PERF_EN.
module hazard_unit #(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              control_sel,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_freeze
`ifdef HAZARD_UNIT_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
        $error("hazard_unit: LOAD_STALL_CYCLES must be 1..15 and CNT_W >= 1");
    end

    logic [1:0] state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       saved, next_saved;
    logic       lu_hit;
    logic       in_stall;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
    assign in_stall = (state == LU_STALL) || ((state == MEM_WAIT) && saved);

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_saved  = saved;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control_sel = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;

        if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
            next_state  = MEM_WAIT;
            next_saved  = (state == MEM_WAIT) ? saved : (state == LU_STALL);
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            next_state  = RUN;
            next_cnt    = '0;
        end else if (in_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if (cnt <= 4'd1) begin
                next_state = RUN;
                next_cnt   = '0;
            end else begin
                next_state = LU_STALL;
                next_cnt   = cnt - 4'd1;
            end
        end else if (lu_hit) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
                next_state = LU_STALL;
                next_cnt   = STALL_RELOAD;
            end else begin
                next_state = RUN;
            end
        end else begin
            next_state = RUN;
        end

        // Hold everything off while reset is asserted.
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            saved <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            saved <= next_saved;
        end
    end

`ifdef HAZARD_UNIT_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!control_sel && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (if_id_flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (single- and triple-bubble builds).
// Perf counter checks run only when HAZARD_UNIT_PERF_EN is defined.
module tb_hazard_unit;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       mb;
        logic [5:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;

    logic pw1, iw1, cs1, ff1, ef1, pf1;
    logic pw3, iw3, cs3, ff3, ef3, pf3;
    logic [5:0] out1, out3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign out1 = {pw1, iw1, cs1, ff1, ef1, pf1};
    assign out3 = {pw3, iw3, cs3, ff3, ef3, pf3};

`ifdef HAZARD_UNIT_PERF_EN
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [3:0]  scp, fcp;
    logic        pwp, iwp, csp, ffp, efp, pfp;
`endif

    hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw1), .if_id_write(iw1), .control_sel(cs1),
        .if_id_flush(ff1), .id_ex_flush(ef1), .pipe_freeze(pf1)
`ifdef HAZARD_UNIT_PERF_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .CNT_W(32)) u3 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pw3), .if_id_write(iw3), .control_sel(cs3),
        .if_id_flush(ff3), .id_ex_flush(ef3), .pipe_freeze(pf3)
`ifdef HAZARD_UNIT_PERF_EN
        , .stall_count(sc3), .flush_count(fc3)
`endif
    );

`ifdef HAZARD_UNIT_PERF_EN
    hazard_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .CNT_W(4)) u_perf (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pwp), .if_id_write(iwp), .control_sel(csp),
        .if_id_flush(ffp), .id_ex_flush(efp), .pipe_freeze(pfp),
        .stall_count(scp), .flush_count(fcp)
    );
`endif

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1_i, input logic u2_i, input logic [4:0] rd,
                                input logic mr, input logic br, input logic mb,
                                input logic [5:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1_i; v.u2 = u2_i; v.rd = rd;
        v.mr = mr; v.br = br; v.mb = mb; v.exp = exp;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_uses_rs1  = v.u1;
        id_uses_rs2  = v.u2;
        ex_rd        = v.rd;
        ex_mem_read  = v.mr;
        branch_taken = v.br;
        mem_busy     = v.mb;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and check one instance shortly after.
    task automatic step(input string name, input vec_t v, input bit use_u3);
        @(negedge clk);
        apply_stimulus(v);
        #2;
        check_output(name, use_u3 ? {26'd0, out3} : {26'd0, out1}, {26'd0, v.exp});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [5:0] PASS_O = 6'b111000;
    localparam logic [5:0] BUBL_O = 6'b000000;
    localparam logic [5:0] FLSH_O = 6'b111110;
    localparam logic [5:0] FRZ_O  = 6'b001001;

    vec_t vecs[14];
    vec_t idle, haz7;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, PASS_O);
        haz7 = mk(3, 7, 1, 1, 7, 1, 0, 0, BUBL_O);

        vecs[0]  = mk(1, 2, 1, 1, 5, 1, 0, 0, PASS_O);
        vecs[1]  = mk(5, 2, 1, 0, 5, 1, 0, 0, BUBL_O);
        vecs[2]  = mk(5, 2, 1, 0, 5, 0, 0, 0, PASS_O);
        vecs[3]  = mk(0, 2, 1, 0, 0, 1, 0, 0, PASS_O);
        vecs[4]  = mk(5, 2, 0, 0, 5, 1, 0, 0, PASS_O);
        vecs[5]  = mk(1, 7, 1, 1, 7, 1, 0, 0, BUBL_O);
        vecs[6]  = mk(1, 7, 1, 0, 7, 1, 0, 0, PASS_O);
        vecs[7]  = mk(5, 2, 1, 0, 5, 1, 1, 0, FLSH_O);
        vecs[8]  = mk(5, 2, 1, 0, 5, 1, 1, 1, FRZ_O);
        vecs[9]  = mk(5, 2, 1, 0, 5, 1, 0, 1, FRZ_O);
        vecs[10] = mk(5, 2, 1, 0, 5, 1, 0, 0, BUBL_O);
        vecs[11] = mk(5, 2, 1, 0, 5, 0, 0, 0, PASS_O);
        vecs[12] = mk(1, 2, 1, 1, 9, 0, 0, 1, FRZ_O);
        vecs[13] = mk(1, 2, 1, 1, 9, 0, 1, 0, FLSH_O);

        reset = 1'b1;
        apply_stimulus(idle);
        @(negedge clk);
        #2;
        check_output("reset_u1", {26'd0, out1}, 32'd0);
        check_output("reset_u3", {26'd0, out3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            step($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Three-bubble stall aborted by a branch in its second cycle.
        pulse_reset();
        step("brk_bubble1", haz7, 1'b1);
        step("brk_branch", mk(3, 7, 1, 1, 7, 0, 1, 0, FLSH_O), 1'b1);
        step("brk_after1", idle, 1'b1);
        step("brk_after2", idle, 1'b1);

        // Memory wait in the middle of a stall keeps the remaining bubbles.
        pulse_reset();
        step("mw_bubble1", haz7, 1'b1);
        for (int i = 0; i < 4; i++)
            step($sformatf("mw_freeze%0d", i), mk(3, 7, 1, 1, 7, 1, 0, 1, FRZ_O), 1'b1);
        step("mw_bubble2", haz7, 1'b1);
        step("mw_bubble3", haz7, 1'b1);
        step("mw_done", idle, 1'b1);

        // Reset in the middle of a stall discards it.
        pulse_reset();
        step("rs_bubble1", haz7, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(haz7);
        #2;
        check_output("rs_during", {26'd0, out3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(idle);
        #2;
        check_output("rs_release", {26'd0, out3}, {26'd0, PASS_O});
        step("rs_next", idle, 1'b1);

`ifdef HAZARD_UNIT_PERF_EN
        pulse_reset();
        #2;
        check_output("perf_stall0", {28'd0, scp}, 32'd0);
        check_output("perf_flush0", {28'd0, fcp}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_stimulus(haz7);
        end
        @(negedge clk);
        apply_stimulus(idle);
        #2;
        check_output("perf_stall10", {28'd0, scp}, 32'd10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_stimulus(haz7);
        end
        @(negedge clk);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, FLSH_O));
        #2;
        check_output("perf_stall_sat", {28'd0, scp}, 32'd15);
        @(negedge clk);
        apply_stimulus(idle);
        #2;
        check_output("perf_flush1", {28'd0, fcp}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_STALL_CYCLES, default 1, legal 1..15, bubbles inserted per load-use hazard.
REQ-003 SHALL have parameter CNT_W, default 32, perf-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
REQ-007 id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2.
REQ-008 ex_rd  in  REG_AW  destination register of the instruction in EX.
REQ-009 ex_mem_read  in  1  EX instruction is a load.
REQ-010 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-011 mem_busy  in  1  data memory not ready; the whole pipeline must hold.
REQ-012 pc_write  out  1  1 = PC may update.
REQ-013 if_id_write  out  1  1 = IF/ID register may load.
REQ-014 control_sel  out  1  1 = pass ID controls to ID/EX; 0 = insert bubble (zero controls).
REQ-015 if_id_flush, id_ex_flush  out  1  squash IF/ID and ID/EX contents.
REQ-016 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers.

Function
REQ-017 Hazard detect SHALL be: lu_hit = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)); x0 never causes a stall.
REQ-018 FSM states SHALL be RUN, LU_STALL, MEM_WAIT, with a 4-bit down-counter cnt and a 1-bit saved-state flag.
REQ-019 Priority SHALL be: mem_busy > branch_taken > lu_hit / LU_STALL.
REQ-020 RUN, no event: pc_write=1, if_id_write=1, control_sel=1, flushes=0, pipe_freeze=0.
REQ-021 RUN with lu_hit: outputs pc_write=0, if_id_write=0, control_sel=0 the same cycle (Mealy); if LOAD_STALL_CYCLES>1, next state LU_STALL with cnt=LOAD_STALL_CYCLES-1, else stay RUN.
REQ-022 LU_STALL: outputs as REQ-021 regardless of lu_hit; cnt decrements each cycle; at cnt==1, next state RUN; total bubbles = LOAD_STALL_CYCLES exactly.
REQ-023 branch_taken (no mem_busy) in RUN or LU_STALL: pc_write=1, if_id_write=1, control_sel=1, if_id_flush=1, id_ex_flush=1; a pending LU_STALL SHALL be aborted (next state RUN, cnt=0).
REQ-024 mem_busy in any state: pc_write=0, if_id_write=0, control_sel=1, flushes=0, pipe_freeze=1; next state MEM_WAIT; saved flag records RUN vs LU_STALL; cnt frozen.
REQ-025 MEM_WAIT with mem_busy=0: return to the saved state with cnt unchanged, evaluating outputs that cycle per that state's rules.
REQ-026 branch_taken or lu_hit asserted during mem_busy SHALL be ignored until mem_busy deasserts (EX is frozen, so the inputs persist).

Reset
REQ-027 While reset=1: state RUN, cnt=0, saved flag=0; pc_write=0, if_id_write=0, control_sel=0, if_id_flush=0, id_ex_flush=0, pipe_freeze=0.
REQ-028 Reset mid-stall or mid-MEM_WAIT SHALL discard all pending stall state; first cycle after release behaves as RUN.

Configuration
REQ-029 Macro HAZARD_UNIT_PERF_EN defined: ports stall_count and flush_count (out, CNT_W) SHALL exist, incrementing once per cycle with control_sel=0 (stall) or if_id_flush=1 (flush), saturating at all-ones, cleared by reset; undefined: ports and logic absent, all other behaviour identical.

Verification
REQ-030 LOAD_STALL_CYCLES=1, ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> exactly one cycle of pc_write=0, if_id_write=0, control_sel=0, then 1/1/1.
REQ-031 Same stimulus with ex_rd=0, or id_uses_rs1=0 -> no stall; outputs stay 1/1/1.
REQ-032 LOAD_STALL_CYCLES=3, hazard on rs2=7 -> 3 consecutive bubble cycles; branch_taken=1 in the 2nd -> both flushes=1 that cycle, RUN next, only 1 more bubble never occurs.
REQ-033 LOAD_STALL_CYCLES=3, mem_busy=1 for 4 cycles after the first bubble -> pipe_freeze=1 for 4 cycles, then the remaining 2 bubbles.
REQ-034 reset pulsed in LU_STALL -> outputs 0/0/0 during reset; 1/1/1 the first cycle after release with no hazard.
REQ-035 HAZARD_UNIT_PERF_EN, CNT_W=4, 20 stall cycles -> stall_count saturates at 15.
